// File: rtl/link_responder_pkg.sv
// Shared packet layout, type codes and FSM encodings for the link responder.
package link_responder_pkg;

  localparam int unsigned PacketSize  = 16;
  localparam int unsigned PayloadSize = PacketSize - 5;

  // Packet layout, MSB first: type, seq, payload, even parity bit.
  typedef struct packed {
    logic [1:0]             ptype;
    logic [1:0]             seq;
    logic [PayloadSize-1:0] payload;
    logic                   parity;
  } packet_t;

  localparam logic [1:0] PktData = 2'b00;
  localparam logic [1:0] PktAck  = 2'b01;
  localparam logic [1:0] PktNak  = 2'b10;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StCheck  = 2'd1;
  localparam logic [1:0] StSend   = 2'd2;
  localparam logic [1:0] StWaitTx = 2'd3;

endpackage

// File: rtl/link_responder_packet_builder.sv
// Combinational packet former: packs the fields and appends even parity.
module link_responder_packet_builder
  import link_responder_pkg::*;
(
  input  logic [1:0]             ptype_i,
  input  logic [1:0]             seq_i,
  input  logic [PayloadSize-1:0] payload_i,
  output packet_t                packet_o
);

  // Parity bit makes the XOR over the whole packet zero.
  always_comb begin
    packet_o.ptype   = ptype_i;
    packet_o.seq     = seq_i;
    packet_o.payload = payload_i;
    packet_o.parity  = ^{ptype_i, seq_i, payload_i};
  end

endmodule

// File: rtl/link_responder.sv
// Receive-side stop-and-wait engine: checks DATA packets, delivers in-order
// payloads to the host and answers each with an ACK or NAK.
module link_responder
  import link_responder_pkg::*;
#(
  parameter int unsigned TxTimeout = 50000
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   irq_rx_i,
  input  logic [PacketSize-1:0]  rx_packet_i,
  input  logic                   irq_tx_i,
  output logic                   tx_enable_o,
  output logic [PacketSize-1:0]  tx_packet_o,
  output logic [PayloadSize-1:0] payload_o,
  output logic                   payload_valid_o,
  input  logic                   payload_ready_i,
  output logic [1:0]             expected_seq_o,
  output logic                   busy_o,
  output logic [7:0]             err_count_o
);

  localparam int unsigned CntW = (TxTimeout > 2) ? $clog2(TxTimeout) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TxTimeout - 1);

  logic [1:0]             state_q, state_d;
  logic                   irq_rx_q, irq_tx_q;
  packet_t                rx_q, rx_d;
  packet_t                tx_q, tx_d;
  logic [PayloadSize-1:0] payload_q, payload_d;
  logic                   pvalid_q, pvalid_d;
  logic [1:0]             exp_q, exp_d;
  logic [7:0]             err_q, err_d;
  logic [CntW-1:0]        cnt_q, cnt_d;

  logic    rx_edge, tx_edge;
  packet_t chk_pkt, resp_pkt;
  logic    parity_ok;
  logic    resp_send, deliver, parity_err, timeout, overrun;
  logic [1:0] resp_type, resp_seq;

  assign rx_edge = irq_rx_i & ~irq_rx_q;
  assign tx_edge = irq_tx_i & ~irq_tx_q;

  // Rebuilding the captured fields reproduces the packet only if parity holds.
  link_responder_packet_builder u_chk (
    .ptype_i   (rx_q.ptype),
    .seq_i     (rx_q.seq),
    .payload_i (rx_q.payload),
    .packet_o  (chk_pkt)
  );
  assign parity_ok = (chk_pkt == rx_q);

  link_responder_packet_builder u_resp (
    .ptype_i   (resp_type),
    .seq_i     (resp_seq),
    .payload_i ('0),
    .packet_o  (resp_pkt)
  );

  // Response decision for the captured packet.
  always_comb begin
    resp_send  = 1'b0;
    resp_type  = PktNak;
    resp_seq   = exp_q;
    deliver    = 1'b0;
    parity_err = 1'b0;
    if (!parity_ok) begin
      resp_send  = 1'b1;
      parity_err = 1'b1;
    end else if (rx_q.ptype == PktData) begin
      resp_send = 1'b1;
      if (rx_q.seq == exp_q) begin
        // Host buffer full: NAK so the initiator retries later.
        if (!pvalid_q) begin
          deliver   = 1'b1;
          resp_type = PktAck;
        end
      end else if (rx_q.seq == exp_q - 2'd1) begin
        // Duplicate of the last delivered packet: our ACK was lost, re-ACK it.
        resp_type = PktAck;
        resp_seq  = rx_q.seq;
      end
    end
  end

  // FSM, payload handshake and error counting.
  always_comb begin
    state_d   = state_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    payload_d = payload_q;
    pvalid_d  = pvalid_q;
    exp_d     = exp_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    timeout   = 1'b0;
    overrun   = rx_edge && (state_q != StIdle);

    if (pvalid_q && payload_ready_i) begin
      pvalid_d = 1'b0;
    end

    case (state_q)
      StIdle: begin
        if (rx_edge) begin
          rx_d    = rx_packet_i;
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (deliver) begin
          payload_d = rx_q.payload;
          pvalid_d  = 1'b1;
          exp_d     = exp_q + 2'd1;
        end
        if (resp_send) begin
          tx_d    = resp_pkt;
          state_d = StSend;
        end else begin
          state_d = StIdle;
        end
      end
      StSend: begin
        cnt_d   = '0;
        state_d = StWaitTx;
      end
      default: begin
        if (tx_edge) begin
          state_d = StIdle;
        end else if (cnt_q == CntLast) begin
          timeout = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
    endcase

    // Coincident error sources count once; saturate at 255.
    if (((state_q == StCheck) && parity_err) || timeout || overrun) begin
      if (err_q != 8'hFF) begin
        err_d = err_q + 8'd1;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      irq_rx_q  <= 1'b0;
      irq_tx_q  <= 1'b0;
      rx_q      <= '0;
      tx_q      <= '0;
      payload_q <= '0;
      pvalid_q  <= 1'b0;
      exp_q     <= 2'd0;
      err_q     <= 8'd0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      irq_rx_q  <= irq_rx_i;
      irq_tx_q  <= irq_tx_i;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      payload_q <= payload_d;
      pvalid_q  <= pvalid_d;
      exp_q     <= exp_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign tx_enable_o     = (state_q == StSend);
  assign tx_packet_o     = tx_q;
  assign payload_o       = payload_q;
  assign payload_valid_o = pvalid_q;
  assign expected_seq_o  = exp_q;
  assign busy_o          = (state_q != StIdle);
  assign err_count_o     = err_q;

endmodule

// File: tb/tb_link_responder.sv
// Directed bench for link_responder with hand-computed packets (16-bit packets).
module tb_link_responder;

  logic        clk;
  logic        rst_n;
  logic        irq_rx;
  logic [15:0] rx_packet;
  logic        irq_tx;
  logic        tx_enable;
  logic [15:0] tx_packet;
  logic [10:0] payload;
  logic        payload_valid;
  logic        payload_ready;
  logic [1:0]  expected_seq;
  logic        busy;
  logic [7:0]  err_count;

  int n_checks = 0;
  int n_fail   = 0;

  link_responder #(
    .TxTimeout (20)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .irq_rx_i        (irq_rx),
    .rx_packet_i     (rx_packet),
    .irq_tx_i        (irq_tx),
    .tx_enable_o     (tx_enable),
    .tx_packet_o     (tx_packet),
    .payload_o       (payload),
    .payload_valid_o (payload_valid),
    .payload_ready_i (payload_ready),
    .expected_seq_o  (expected_seq),
    .busy_o          (busy),
    .err_count_o     (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Present a packet with an irq_rx rising edge. With expect_tx, tx_enable must be
  // seen right after edge 1 (i.e. sampled high by edge 2), then return in WAIT_TX.
  task automatic rx_pkt(input string tag, input logic [15:0] pkt, input bit expect_tx);
    int seen;
    seen = -1;
    @(negedge clk);
    rx_packet = pkt;
    irq_rx    = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) irq_rx = 1'b0;
      if (tx_enable && seen < 0) seen = k;
      if (expect_tx && seen >= 0) break;
    end
    if (expect_tx) begin
      check({tag, "_lat"}, seen, 1);
      @(posedge clk);
      #1;
    end else begin
      check({tag, "_no_tx"}, seen, 32'hFFFF_FFFF);
    end
  endtask

  // Pulse irq_tx while waiting; the engine must be idle afterwards.
  task automatic tx_done(input string tag);
    @(negedge clk);
    irq_tx = 1'b1;
    @(negedge clk);
    irq_tx = 1'b0;
    check({tag, "_idle"}, busy, 0);
  endtask

  // Host accepts the pending payload.
  task automatic accept(input string tag);
    @(negedge clk);
    payload_ready = 1'b1;
    @(negedge clk);
    payload_ready = 1'b0;
    check({tag, "_accepted"}, payload_valid, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_en"}, tx_enable, 0);
    check({tag, "_tx_pkt"}, tx_packet, 0);
    check({tag, "_payload"}, payload, 0);
    check({tag, "_pvalid"}, payload_valid, 0);
    check({tag, "_exp"}, expected_seq, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_err"}, err_count, 0);
  endtask

  initial begin
    int n;
    rst_n         = 1'b1;
    irq_rx        = 1'b0;
    irq_tx        = 1'b0;
    rx_packet     = '0;
    payload_ready = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // In-order DATA seq 0, payload 0x155 -> ACK seq 0 = 0x4001.
    rx_pkt("d0", 16'h02AB, 1'b1);
    check("d0_tx", tx_packet, 16'h4001);
    check("d0_payload", payload, 11'h155);
    check("d0_pvalid", payload_valid, 1);
    check("d0_exp", expected_seq, 1);
    tx_done("d0");

    // DATA seq 1 (payload 0x0F0) with parity flipped -> NAK seq 1 = 0x9000.
    rx_pkt("bad", 16'h11E0, 1'b1);
    check("bad_tx", tx_packet, 16'h9000);
    check("bad_pvalid", payload_valid, 1);
    check("bad_err", err_count, 1);
    check("bad_exp", expected_seq, 1);
    tx_done("bad");

    // Duplicate seq 0 -> ACK seq 0, no new delivery.
    rx_pkt("dup", 16'h02AB, 1'b1);
    check("dup_tx", tx_packet, 16'h4001);
    check("dup_payload", payload, 11'h155);
    check("dup_exp", expected_seq, 1);
    tx_done("dup");

    // Seq 1 while host buffer full -> NAK seq 1.
    rx_pkt("full", 16'h11E1, 1'b1);
    check("full_tx", tx_packet, 16'h9000);
    check("full_payload", payload, 11'h155);
    check("full_exp", expected_seq, 1);
    tx_done("full");

    // Host drains, resend -> ACK seq 1 = 0x5000.
    accept("a1");
    rx_pkt("d1", 16'h11E1, 1'b1);
    check("d1_tx", tx_packet, 16'h5000);
    check("d1_payload", payload, 11'h0F0);
    check("d1_exp", expected_seq, 2);
    tx_done("d1");

    // Seq 2, payload 0x001 -> ACK seq 2 = 0x6000; no irq_tx -> timeout after 20 cycles.
    accept("a2");
    rx_pkt("d2", 16'h2002, 1'b1);
    check("d2_tx", tx_packet, 16'h6000);
    check("d2_exp", expected_seq, 3);
    n = 0;
    while (busy && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("timeout_cycles", n, 20);
    check("timeout_err", err_count, 2);

    // Seq 3, payload 0x002 -> ACK seq 3 = 0x7001; irq_rx edge during WAIT_TX is dropped.
    accept("a3");
    rx_pkt("d3", 16'h3005, 1'b1);
    check("d3_tx", tx_packet, 16'h7001);
    check("d3_exp", expected_seq, 0);
    @(negedge clk);
    rx_packet = 16'h0FFF;
    irq_rx    = 1'b1;
    @(negedge clk);
    irq_rx = 1'b0;
    check("ovr_err", err_count, 3);
    check("ovr_payload", payload, 11'h002);
    tx_done("ovr");
    check("ovr_exp", expected_seq, 0);
    check("ovr_tx", tx_packet, 16'h7001);

    // Wrap: seq 0, payload 0x7FF -> ACK seq 0.
    accept("a4");
    rx_pkt("wrap", 16'h0FFF, 1'b1);
    check("wrap_tx", tx_packet, 16'h4001);
    check("wrap_payload", payload, 11'h7FF);
    check("wrap_exp", expected_seq, 1);
    tx_done("wrap");

    // Good-parity ACK packet from the far end: no response.
    accept("a5");
    rx_pkt("ack_in", 16'h4001, 1'b0);
    check("ack_in_busy", busy, 0);
    check("ack_in_err", err_count, 3);
    check("ack_in_exp", expected_seq, 1);

    // Seq 1, payload 0x123 -> ACK seq 1, then reset asynchronously mid WAIT_TX.
    rx_pkt("d5", 16'h1247, 1'b1);
    check("d5_tx", tx_packet, 16'h5000);
    check("d5_exp", expected_seq, 2);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("async");
    @(negedge clk);
    rst_n = 1'b1;
    tx_done("late_tx");
    check("late_tx_pkt", tx_packet, 0);
    check("late_tx_err", err_count, 0);
    check("late_tx_en", tx_enable, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/link_responder.md
# link_responder

Receive-side protocol engine for the optical link. It sits between the `transceiver` packet ports and the host. Each received DATA packet is checked, in-order payloads are delivered to the host, and an ACK or NAK packet is sent back over the same LED link. It is the responding end of the stop-and-wait scheme whose initiator retransmits until it sees an ACK.

## Interface
Parameters:
- TX_TIMEOUT, 50000, cycles to wait for `irq_tx` after launching a response before abandoning it.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- irq_rx  in  1  packet-received indication from the transceiver (level or pulse; edge-detected).
- rx_packet  in  `PACKET_SIZE  received packet (transceiver `data_out`).
- irq_tx  in  1  packet-sent indication from the transceiver (edge-detected).
- tx_enable  out  1  one-cycle pulse launching a response.
- tx_packet  out  `PACKET_SIZE  response packet (transceiver `data_in`); held stable from `tx_enable` until the state returns to IDLE.
- payload  out  `PAYLOAD_SIZE  delivered payload.
- payload_valid  out  1  payload holds undelivered data.
- payload_ready  in  1  host accepts payload when high with payload_valid.
- expected_seq  out  2  next in-order sequence number.
- busy  out  1  state != IDLE.
- err_count  out  8  saturating count of parity errors, overruns and TX timeouts.

## Operation
- Packet format, with P = `PACKET_SIZE` (P ≥ 6):
  - [P-1:P-2] type: 00 DATA, 01 ACK, 10 NAK, 11 reserved.
  - [P-3:P-4] seq.
  - [P-5:1] payload.
  - [0] even parity over the whole packet, so XOR of all bits = 0.
- FSM states: IDLE → CHECK → SEND → WAIT_TX → IDLE.
- IDLE: on the `irq_rx` rising edge, register `rx_packet` and go to CHECK.
- CHECK decides the response in a single cycle:
  - Parity bad: NAK(seq = expected_seq); err_count+1.
  - DATA, seq == expected_seq, payload_valid low: load payload, set payload_valid, send ACK(seq), expected_seq+1 (mod 4).
  - DATA, seq == expected_seq, payload_valid high (host buffer full): NAK(expected_seq); nothing delivered; seq does not advance.
  - DATA, seq == expected_seq−1 (mod 4), i.e. a duplicate: ACK(seq) again; nothing delivered.
  - DATA, any other seq: NAK(expected_seq).
  - Type ACK, NAK or reserved with good parity: no response; return to IDLE.
- Response packets carry a zero payload and correct parity.
- SEND: assert `tx_enable` for one cycle, clear the timeout counter, go to WAIT_TX.
- WAIT_TX:
  - `irq_tx` rising edge → IDLE.
  - Counter reaching TX_TIMEOUT−1 → IDLE and err_count+1.
- An `irq_rx` edge outside IDLE is an overrun: the packet is dropped and err_count+1. The link is half-duplex and does not queue.
- Payload handshake: a transfer occurs when payload_valid && payload_ready; payload_valid clears on the next cycle.
  - A CHECK load and a host accept in the same cycle cannot conflict, because a load requires payload_valid low.
- err_count saturates at 255. Two increment sources in one cycle add once.

## Timing
- Cycle numbering, with cycle 0 = first clock edge sampling `irq_rx` high after low:
  - Edge 0: packet captured, state = CHECK.
  - Edge 1: tx_packet registered; payload_valid and expected_seq update; state = SEND.
  - Cycle 2: `tx_enable` = 1.
  - Edge 2: state = WAIT_TX.
- Receive-to-launch latency is therefore 2 cycles.
- Edge detectors are registered. An `irq_rx` held high produces exactly one event.
- Reset values: state IDLE; tx_enable 0; tx_packet 0; payload 0; payload_valid 0; expected_seq 0; busy 0; err_count 0; edge-detect history 0.
- Reset asserted mid-operation aborts immediately.
  - A `tx_enable` pulse already issued is not retracted.
  - A late `irq_tx` edge arriving in IDLE is ignored.

## Structure
- `definitions.v` holds:
  - Field offsets.
  - Type codes `PKT_DATA`/`PKT_ACK`/`PKT_NAK`.
  - `PAYLOAD_SIZE` = `PACKET_SIZE`−5.
  - FSM state encodings.
- One combinational sub-module, `packet_builder`, forms {type, seq, payload, parity} and is also used for the parity check.
- Everything else lives in `link_responder`.

## Test plan
The bench uses PACKET_SIZE = 16, PAYLOAD_SIZE = 11 and TX_TIMEOUT = 20.
- In-order DATA: DATA seq 0, payload 0x155 → tx_enable two cycles after capture. tx_packet = ACK seq 0 (0x4000 with parity fixed). payload = 0x155, payload_valid = 1, expected_seq = 1.
- Bad parity: DATA seq 1 with bit 0 flipped → NAK seq 1. payload_valid unchanged. err_count = 1.
- Duplicate and full buffer:
  - Resend DATA seq 0 after expected_seq = 1 → ACK seq 0; no new delivery.
  - DATA seq 1 while payload_valid is still 1 → NAK seq 1.
  - Assert payload_ready, then resend → ACK seq 1.
- TX timeout and overrun:
  - Never pulse `irq_tx` → state back to IDLE after 20 WAIT_TX cycles; err_count+1.
  - An `irq_rx` edge during WAIT_TX → dropped; err_count+1.
- Wrap and reset:
  - Deliver seq 0..3 then seq 0 → all ACKed; expected_seq wraps 3→0.
  - Drop reset to 0 while in WAIT_TX → all outputs return to reset values asynchronously.
  - A following `irq_tx` edge does nothing.
